// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory port: access-size codes, FSM states
// and the byte-enable helper.
package mem_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // 8-lane mask; callers keep only the lanes their data width has.
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/dmem_lane_extract.sv
// Combinational load lane select with sign/zero extension; shared with the
// cache-fill path.
module dmem_lane_extract
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int LB    = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [LB-1:0]     offset,
  input  logic [1:0]        size,
  input  logic              sext,
  output logic [DATA_W-1:0] data_out
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep_mask;
  logic [DATA_W-1:0] msb_mask;
  logic              fill;

  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    case (size)
      SZ_B:    keep_mask = DATA_W'(64'h0000_0000_0000_00FF);
      SZ_H:    keep_mask = DATA_W'(64'h0000_0000_0000_FFFF);
      SZ_W:    keep_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
      default: keep_mask = '1;
    endcase
    // A full-width mask leaves no fill bits, so full-width loads pass through.
    msb_mask = keep_mask ^ (keep_mask >> 1);
    fill     = sext & (|(shifted & msb_mask));
    data_out = (shifted & keep_mask) | ({DATA_W{fill}} & ~keep_mask);
  end

endmodule

// File: rtl/dmem_port_ctrl.sv
// Registered, handshaked load/store port between the MEM stage and a
// synchronous data RAM with per-byte write enables and READ_LAT-cycle reads.
module dmem_port_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MEM_AW   = 8,
  parameter int READ_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic                  req_we,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [1:0]            req_size,
  input  logic                  req_sext,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int NB = DATA_W / 8;
  localparam int LB = $clog2(NB);
  localparam int AQ = MEM_AW + LB;
  localparam int CW = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AQ-1:0]     addr_q, addr_d;
  logic              we_q, we_d;
  logic              sext_q, sext_d;
  logic              err_q, err_d;
  logic [1:0]        size_q, size_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              misaligned;
  logic              illegal;
  logic [7:0]        be_full;
  logic [DATA_W-1:0] wdata_rep;
  logic [DATA_W-1:0] load_data;
  logic              unused_addr_hi;
  logic              unused_be;

  assign unused_addr_hi = ^req_addr[ADDR_W-1:AQ];
  assign unused_be      = ^be_full;

  always_comb begin
    case (req_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      default: misaligned = |req_addr[2:0];
    endcase
  end

  assign illegal = (req_size == SZ_D) && (DATA_W == 32);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    sext_d  = sext_q;
    err_d   = err_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr[AQ-1:0];
          we_d    = req_we;
          wdata_d = req_wdata;
          size_d  = req_size;
          sext_d  = req_sext;
          err_d   = misaligned | illegal;
          rdata_d = '0;
          state_d = (misaligned | illegal) ? S_RESP : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = CW'(READ_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          rdata_d = load_data;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (size_q)
      SZ_B:    wdata_rep = {NB{wdata_q[7:0]}};
      SZ_H:    wdata_rep = {(NB / 2){wdata_q[15:0]}};
      SZ_W:    wdata_rep = {(NB / 4){wdata_q[31:0]}};
      default: wdata_rep = wdata_q;
    endcase
  end

  dmem_lane_extract #(
    .DATA_W (DATA_W)
  ) u_extract (
    .rdata    (mem_rdata),
    .offset   (addr_q[LB-1:0]),
    .size     (size_q),
    .sext     (sext_q),
    .data_out (load_data)
  );

  assign be_full    = be_mask(size_q, 3'(addr_q[LB-1:0]));
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_valid & err_q;
  assign resp_rdata = resp_valid ? rdata_q : '0;
  assign mem_req    = (state_q == S_ISSUE);
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = mem_req ? addr_q[AQ-1:LB] : '0;
  assign mem_be     = mem_req ? be_full[NB-1:0] : '0;
  assign mem_wdata  = mem_req ? wdata_rep : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sext_q  <= sext_d;
      err_q   <= err_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: doc/dmem_port_ctrl.md
Name: dmem_port_ctrl

Overview:
- Registered, handshaked data-memory port that replaces the combinational load/store port between the core's MEM stage and a synchronous data RAM.
- Supports byte, half, word and (when DATA_W=64) dword accesses, with sign/zero extension on loads.
- Uses true per-byte write enables instead of read-modify-write masking, flags misaligned accesses, and tolerates a parametrised RAM read latency.

Parameters:
- ADDR_W, 32: byte-address width of requests.
- DATA_W, 32: data width; legal values are 32 and 64.
- MEM_AW, 8: word-index width of the RAM.
- READ_LAT, 1: cycles from mem_req to mem_rdata valid; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  port can accept a request.
- req_addr  in  ADDR_W  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  DATA_W  store data, right-aligned.
- req_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword.
- req_sext  in  1  sign-extend the load result.
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  DATA_W  load result; 0 for stores and errors.
- resp_err  out  1  misaligned access, or illegal size.
- mem_req  out  1  RAM access strobe.
- mem_we  out  1  RAM write.
- mem_addr  out  MEM_AW  word index: req_addr[MEM_AW+LB-1:LB], where LB = log2(DATA_W/8).
- mem_be  out  DATA_W/8  byte enables.
- mem_wdata  out  DATA_W  lane-replicated store data.
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and the latency counter clears.
  - All outputs are 0 except req_ready, which is 1.
  - Any in-flight transaction is dropped with no response.
- Accept: a request is taken on a rising edge where req_valid & req_ready. The port latches addr, we, wdata, size and sext.
- req_ready is 1 only in IDLE. There is exactly one outstanding transaction.
- Error check at accept:
  - Misaligned when addr mod 2^size != 0.
  - size=3 is illegal when DATA_W=32.
  - On error: go straight to RESP with resp_err=1 and resp_rdata=0. No mem_req is issued.
- States:
  - IDLE: on accept, go to ISSUE, or to RESP on error.
  - ISSUE: one cycle. mem_req=1, mem_we=latched we, mem_addr and mem_be driven.
    - Store: go to RESP.
    - Load: load cnt=READ_LAT and go to WAIT.
  - WAIT: decrement cnt each cycle. In the cycle where cnt==1, capture the extracted mem_rdata into resp_rdata and go to RESP.
  - RESP: resp_valid=1, outputs held stable. On resp_ready, go to IDLE.
- Byte enables:
  - Base mask is (2^(2^size))-1, shifted left by the low offset bits of addr.
  - mem_wdata replicates the low 2^size bytes of wdata across all lanes.
  - mem_be and mem_we are 0 outside ISSUE. mem_addr and mem_wdata are don't-care outside ISSUE.
- Load extraction:
  - Select the lane at the offset.
  - Extend bits above 8·2^size with sext & msb of the lane; otherwise zero-fill.
  - Full-width loads pass through unchanged.
- Latency with READ_LAT=1 (accept on edge 0):
  - Load: ISSUE in cycle 1, WAIT in cycle 2, resp_valid in cycle 3.
  - Store: resp_valid in cycle 2.
  - Error: resp_valid in cycle 1.
- resp_valid is held for as long as resp_ready is low. A new request is accepted no earlier than the cycle after the response handshake.

Decomposition:
- Shared package (mem_pkg) holds:
  - The size encodings: SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3.
  - The state enum: IDLE, ISSUE, WAIT, RESP.
  - A function computing be from size and offset.
- One natural sub-module, dmem_lane_extract: combinational lane select plus sign/zero extension, parametrised on DATA_W. It is reused by the future cache-fill path.

Test Plan:
1. Store byte, addr=0x103, wdata=0xAB: mem_addr=0x40, mem_be=4'b1000, mem_wdata=0xABABABAB, mem_we=1 for exactly one cycle; resp_valid in cycle 2 with resp_err=0.
2. RAM word 0x40 = 0x80FF1234; load half at 0x102 with sext=1, then with sext=0: resp_rdata = 0xFFFF80FF, then 0x000080FF.
3. Load word at 0x101: resp_err=1 and resp_rdata=0 in cycle 1, no mem_req ever asserted. size=3 with DATA_W=32 at 0x100 gives the same result.
4. READ_LAT=3, load word at 0x0 with RAM=0xDEADBEEF: resp_valid in cycle 5 with 0xDEADBEEF; req_ready=0 in cycles 1–5.
5. resp_ready held low for 4 cycles: resp_valid and resp_rdata stay stable, req_ready stays 0; a second request accepts only after the handshake.
6. reset asserted during WAIT: all outputs clear immediately, req_ready=1, no resp_valid after release; the next load completes normally.
